// File: rtl/reg32_pwm_out.sv
// PWM generator driven by a 32-bit register word: [31:16] period, [15:0] duty (in ticks).
// Optional complementary output with dead-band insertion when PWM_DEADBAND_EN is defined.
module reg32_pwm_out #(
  parameter int PRESCALE = 1,
  parameter int DEADTIME = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] reg_value,
  output logic        pwm_out,
`ifdef PWM_DEADBAND_EN
  output logic        pwm_out_n,
`endif
  output logic        period_end
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [15:0] presc;
  logic [15:0] count;
  logic [15:0] period_sh;
  logic [15:0] duty_sh;
  logic        tick;
  logic        wrap;
  logic        idle;
  logic        reload;
  logic        raw;

  always_comb begin
    tick   = (presc == PS_LAST);
    idle   = (period_sh == 16'd0);
    wrap   = tick && !idle && (count == period_sh - 16'd1);
    // Shadows only change at a period boundary, or while parked on a zero period.
    reload = !enable || (tick && (idle || wrap));
    raw    = enable && (count < duty_sh);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc      <= 16'd0;
      count      <= 16'd0;
      period_sh  <= 16'd0;
      duty_sh    <= 16'd0;
      period_end <= 1'b0;
    end else if (!enable) begin
      presc      <= 16'd0;
      count      <= 16'd0;
      period_sh  <= reg_value[31:16];
      duty_sh    <= reg_value[15:0];
      period_end <= 1'b0;
    end else begin
      presc      <= tick ? 16'd0 : presc + 16'd1;
      period_end <= wrap;
      if (tick) begin
        if (idle || wrap) count <= 16'd0;
        else              count <= count + 16'd1;
      end
      if (reload) begin
        period_sh <= reg_value[31:16];
        duty_sh   <= reg_value[15:0];
      end
    end
  end

`ifdef PWM_DEADBAND_EN
  localparam logic [7:0] DT = 8'(DEADTIME);

  // Run lengths of the raw waveform, saturating at DT, counted up to the previous clock.
  logic [7:0] hi_run;
  logic [7:0] lo_run;

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      hi_run    <= 8'd0;
      lo_run    <= 8'd0;
      pwm_out   <= 1'b0;
      pwm_out_n <= 1'b0;
    end else begin
      hi_run    <= raw ? ((hi_run == DT) ? DT : hi_run + 8'd1) : 8'd0;
      lo_run    <= !raw ? ((lo_run == DT) ? DT : lo_run + 8'd1) : 8'd0;
      pwm_out   <= raw && (hi_run >= DT);
      pwm_out_n <= !raw && (lo_run >= DT);
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset) pwm_out <= 1'b0;
    else       pwm_out <= raw;
  end
`endif

endmodule

// File: doc/reg32_pwm_out.md
Name: reg32_pwm_out

Overview:
- Downstream consumer of the 32-bit exported register value (Q_export) of the Avalon register slave.
- Software writes one word holding period and duty; this block produces a glitch-free PWM waveform on an external pin.
- New values are double-buffered and take effect only at a period boundary.
- Sits in the system top level, outside the Avalon fabric, on the same clock.

Parameters:
- PRESCALE, 1, clock cycles per PWM count tick; legal range 1..65535.
- DEADTIME, 2, dead-band length in clock cycles; used only when PWM_DEADBAND_EN is defined; legal range 1..255.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  run/stop; 0 stops and clears the generator.
- reg_value  input  32  register contents: [31:16] = period in ticks, [15:0] = duty in ticks.
- pwm_out  output  1  registered PWM output.
- period_end  output  1  one-cycle pulse on the clock where the counter wraps.
- pwm_out_n  output  1  complementary output; present only with PWM_DEADBAND_EN.

Behaviour:
- Reset (reset=1 at clock edge):
  - prescaler, count, period_sh, duty_sh = 0
  - pwm_out = 0, period_end = 0, pwm_out_n = 0
  - reset has priority over enable, at any point mid-period.
- Prescaler: counts 0..PRESCALE-1 while enable=1; tick = 1 on the cycle it equals PRESCALE-1, then it wraps to 0. With PRESCALE=1, tick=1 every cycle.
- Shadow registers:
  - While enable=0: period_sh/duty_sh load from reg_value every cycle; prescaler=0, count=0, pwm_out=0, period_end=0.
  - While enable=1: reload only on the wrap cycle, or on any tick while period_sh==0.
  - Mid-period changes to reg_value have no effect on the current period.
- Counter (16-bit):
  - On tick with period_sh!=0: if count==period_sh-1, count->0, period_end=1 for that cycle, and shadows reload; else count+1.
  - No tick: count holds.
- Output: pwm_out <= enable & (count < duty_sh), one cycle after count.
  - duty_sh=0 -> constant 0.
  - duty_sh>=period_sh -> constant 1 (saturation, no wrap artefact).
- period_sh==0: count held 0, pwm_out=0, period_end never asserted; leaves this state on the first tick after reg_value holds a non-zero period.
- enable falling mid-period: next clock pwm_out=0, count=0, prescaler=0.
- enable rising: the first period starts with count=0 on that cycle, using the values loaded while disabled. pwm_out follows one cycle later.
- Comparisons are unsigned 16-bit; no arithmetic overflow is possible since count < period_sh <= 65535.

Optional Feature:
- Macro: PWM_DEADBAND_EN.
- Defined:
  - pwm_out_n port exists.
  - Raw waveform r = (count < duty_sh).
  - pwm_out rises only after r has been 1 for DEADTIME consecutive clocks; it falls with r.
  - pwm_out_n rises only after r has been 0 for DEADTIME consecutive clocks; it falls when r rises.
  - pwm_out and pwm_out_n are never both 1.
  - High or low phases of DEADTIME clocks or fewer are suppressed on the respective output.
  - Dead-band counter cleared by reset and enable=0; both outputs 0 then.
- Undefined: no pwm_out_n port, no dead-band logic; pwm_out exactly as in Behaviour.

Test Plan:
- Reset check: reset=1 for 2 cycles with enable=1, reg_value=0x000A_0003 -> pwm_out=0, period_end=0; release -> pwm_out high 3 clocks, low 7, period_end pulse every 10 clocks (PRESCALE=1).
- Prescaler: PRESCALE=4, reg_value=0x0005_0002 -> pwm_out high 8 clocks, low 12; period_end every 20 clocks.
- Double-buffering: reg_value changes 0x000A_0003 -> 0x000A_0008 at count=5 -> current period stays 3 high; the next period is 8 high; no extra edges.
- Saturation and zero: duty=0x0010 with period=0x000A -> pwm_out constant 1 with period_end still pulsing; reg_value=0 -> pwm_out 0, no period_end; then write 0x0004_0001 -> resumes at 1 high / 3 low.
- Enable/reset mid-period: deassert enable at count=2 -> pwm_out 0 next clock; re-enable -> restarts at count 0. Assert reset at count=6 -> all outputs 0 next clock.
- PWM_DEADBAND_EN with DEADTIME=2, reg_value=0x000A_0005 -> pwm_out high 3 clocks, pwm_out_n high 3 clocks, 2-clock gaps, never both high. Duty 0x0002 -> pwm_out stays 0.
